// File: rtl/upe_pkg.sv
// Shared widths and state encoding for the UPE result serialiser.
package upe_pkg;
   localparam int UPE_WORD_W = 32;
   localparam int UPE_HALF_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } upe_state_t;
endpackage

// File: rtl/upe_tick_div.sv
// Bit-period prescaler: while enabled, pulses tick on every DIVIDE-th cycle.
module upe_tick_div #(
   parameter int DIVIDE = 1250
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

   logic [CW-1:0] count;

   // Held at zero while disabled so every frame starts a fresh bit period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = en && (count == LAST);
endmodule

// File: rtl/upe_serial_out.sv
// Serialises one 32-bit UPE result word onto a single LED, DIVIDE clocks per bit.
module upe_serial_out
   import upe_pkg::*;
#(
   parameter int DIVIDE    = 1250,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [UPE_WORD_W-1:0] in_data,
   output logic                  led,
   output logic [4:0]            bit_index,
   output logic                  busy,
   output logic                  done
);
   upe_state_t            state;
   upe_state_t            state_next;
   logic [UPE_WORD_W-1:0] shreg;
   logic                  tick;
   logic                  accept;
   logic                  last_bit;

   assign accept   = in_valid && in_ready;
   assign last_bit = (bit_index == 5'd31);

   upe_tick_div #(
      .DIVIDE(DIVIDE)
   ) u_div (
      .clk (clk),
      .rst (rst),
      .en  (busy),
      .tick(tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = SHIFT;
         SHIFT:   if (tick && last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state == SHIFT);
   end

   // The register shifts toward the send end, so the next bit always sits one place in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         led       <= 1'b0;
         bit_index <= 5'd0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            shreg     <= in_data;
            bit_index <= 5'd0;
            led       <= LSB_FIRST ? in_data[0] : in_data[UPE_WORD_W-1];
         end else if (busy && tick) begin
            if (last_bit) begin
               shreg     <= '0;
               led       <= 1'b0;
               bit_index <= 5'd0;
               done      <= 1'b1;
            end else begin
               shreg     <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
               led       <= LSB_FIRST ? shreg[1] : shreg[UPE_WORD_W-2];
               bit_index <= bit_index + 5'd1;
            end
         end
      end
   end
endmodule

// File: doc/upe_serial_out.md
UPE_SERIAL_OUT -- requirements
Module: upe_serial_out

Interface
REQ-001 Parameter DIVIDE, default 1250, is the number of clk cycles each bit is held on led; legal range 1..2^20.
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 is sent first; 0 = bit 31 is sent first.
REQ-003 Port clk, input, 1, the single clock for the block (10 kHz SB_LFOSC in the board build).
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, upstream word available.
REQ-006 Port in_ready, output, 1, block can accept a word.
REQ-007 Port in_data, input, 32, result word {value[31:16], uncertainty[15:0]} from the upe_abs16s stage.
REQ-008 Port led, output, 1, registered serial bit output.
REQ-009 Port bit_index, output, 5, index of the bit currently on led, counted in send order (0..31).
REQ-010 Port busy, output, 1, high while a word is being sent.
REQ-011 Port done, output, 1, one-cycle pulse after the last bit period ends.

Function
REQ-012 The state machine SHALL have exactly two states: IDLE and SHIFT.
REQ-013 in_ready SHALL equal (state == IDLE); busy SHALL equal (state == SHIFT); both are decoded combinationally from the state register.
REQ-014 On a clk edge with in_valid && in_ready, the block SHALL capture in_data into a 32-bit shift register, go to SHIFT, and clear the divider count and bit_index to 0.
REQ-015 On that same edge, led SHALL load the first bit: in_data[0] if LSB_FIRST, else in_data[31].
REQ-016 In SHIFT, the divider count SHALL increment each cycle. When count == DIVIDE-1 it SHALL wrap to 0 and advance the bit.
REQ-017 On a bit advance with bit_index < 31, bit_index SHALL increment and led SHALL load the next bit in send order.
REQ-018 On a bit advance with bit_index == 31, the block SHALL go to IDLE, set led to 0, set bit_index to 0, and assert done for exactly one cycle.
REQ-019 Each bit SHALL be held on led for exactly DIVIDE cycles. done SHALL be high during cycle 32*DIVIDE+1 counted from the accept edge.
REQ-020 When DIVIDE == 1, led SHALL change every cycle; total busy time is 32 cycles.
REQ-021 While busy, in_valid SHALL be ignored and in_data SHALL NOT disturb the word being sent.
REQ-022 A word presented in the cycle where done is high SHALL be accepted, giving back-to-back frames with no idle gap beyond that one cycle.
REQ-023 In IDLE, led SHALL be 0 and the divider SHALL NOT count.

Reset
REQ-024 While rst is high, state SHALL be IDLE and led, bit_index, done, the divider count and the shift register SHALL all be 0. As a result in_ready=1 and busy=0.
REQ-025 An rst assertion during SHIFT SHALL abort the frame immediately. The partial word is discarded, no done pulse is produced, and no word is accepted on the first edge after rst is released unless in_valid is high then.

Structure
REQ-026 Package upe_pkg SHALL hold UPE_WORD_W=32, UPE_HALF_W=16, and the state enumeration {IDLE, SHIFT}.
REQ-027 The bit-period prescaler SHALL be a sub-module named upe_tick_div. Its ports are clk, rst, en and tick; its parameter is DIVIDE; its counter width is $clog2(DIVIDE) with a minimum of 1.
REQ-028 The implementation SHALL be synthesizable for iCE40 and use no vendor primitives.

Verification
REQ-029 DIVIDE=4, LSB_FIRST=1, in_data=32'h34D51531 accepted at edge 0 -> led sequence begins 1,0,0,0,1,1,0,0, each bit held 4 cycles; done high at cycle 129; busy low from then.
REQ-030 DIVIDE=1, LSB_FIRST=0, in_data=32'hCB2BEACF -> led over cycles 1..32 equals bits 31 down to 0, i.e. begins 1,1,0,0,1,0,1,1.
REQ-031 in_valid held high with words 32'hAAAA5555 then 32'h0000FFFF, DIVIDE=2 -> the second word is accepted in the done cycle; its first bit (1) appears on the next cycle.
REQ-032 in_valid pulsed with 32'hFFFFFFFF at bit_index 10 of a frame carrying 32'h00000000 -> led stays 0 for the whole frame; the pulsed word is never sent.
REQ-033 rst asserted at bit_index 20 of a frame, DIVIDE=3 -> led=0, busy=0, in_ready=1 and done=0 asynchronously; the next accepted word starts at bit_index 0.
REQ-034 Idle for 100 cycles with in_valid=0 -> led=0, done=0, and the divider count stays at 0 throughout.
